// File: rtl/stream_demux_pkg.sv
// Shared constants and types for the 1-to-4 stream demultiplexer.
package stream_demux_pkg;

    localparam int N_OUT     = 4;
    localparam int SEL_W     = 2;
    localparam int W_DEF     = 4;
    localparam int CNT_W_DEF = 16;

    typedef logic [SEL_W-1:0] sel_t;

endpackage : stream_demux_pkg

// File: rtl/stream_demux_1_2.sv
// Registered 1-to-2 stream stage: one slot per output, full back-pressure,
// routes on in_route and carries SIDE_W select bits alongside the payload.
module stream_demux_1_2 #(
    parameter int W      = 4,
    parameter int SIDE_W = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [W-1:0]           in_data,
    input  logic                   in_route,
    input  logic [SIDE_W-1:0]      in_side,
    output logic [1:0]             out_valid,
    input  logic [1:0]             out_ready,
    output logic [1:0][W-1:0]      out_data,
    output logic [1:0][SIDE_W-1:0] out_side
);

    logic [1:0]             valid_q, valid_d;
    logic [1:0][W-1:0]      data_q, data_d;
    logic [1:0][SIDE_W-1:0] side_q, side_d;
    logic [1:0]             load_s;

    // Slot load/unload decisions and next-state for both output slots.
    always_comb begin
        in_ready  = out_ready[in_route] | ~valid_q[in_route];
        load_s[0] = in_valid & in_ready & ~in_route;
        load_s[1] = in_valid & in_ready & in_route;
        valid_d   = valid_q;
        data_d    = data_q;
        side_d    = side_q;
        for (int s = 0; s < 2; s++) begin
            if (load_s[s]) begin
                valid_d[s] = 1'b1;
                data_d[s]  = in_data;
                side_d[s]  = in_side;
            end else if (out_ready[s]) begin
                valid_d[s] = 1'b0;
            end else begin
                valid_d[s] = valid_q[s];
            end
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 2'b00;
            data_q  <= '0;
            side_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            side_q  <= side_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_side  = side_q;

endmodule : stream_demux_1_2

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demultiplexer built as a tree of three 1-to-2 stages.
// Optional per-channel delivered-beat counters: define STREAM_DEMUX_CNT_EN.
module stream_demux_1_4
    import stream_demux_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              in_data,
    input  logic [SEL_W-1:0]          in_sel,
    output logic [N_OUT-1:0]          out_valid,
    input  logic [N_OUT-1:0]          out_ready,
    output logic [N_OUT-1:0][W-1:0]   out_data
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [N_OUT-1:0][CNT_W-1:0] beat_cnt
`endif
);

    sel_t              sel_s;
    logic [1:0]        a_valid_s;
    logic [1:0][W-1:0] a_data_s;
    logic [1:0][0:0]   a_side_s;
    logic              b0_ready_s, b1_ready_s;
    logic [1:0][0:0]   b0_side_unused, b1_side_unused;

    assign sel_s = in_sel;

    stream_demux_1_2 #(.W(W), .SIDE_W(1)) u_stage_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_route  (sel_s[1]),
        .in_side   (sel_s[0:0]),
        .out_valid (a_valid_s),
        .out_ready ({b1_ready_s, b0_ready_s}),
        .out_data  (a_data_s),
        .out_side  (a_side_s)
    );

    // Leaf stages carry no further select bits; their side lane is tied off.
    stream_demux_1_2 #(.W(W), .SIDE_W(1)) u_stage_b0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_valid_s[0]),
        .in_ready  (b0_ready_s),
        .in_data   (a_data_s[0]),
        .in_route  (a_side_s[0][0]),
        .in_side   (1'b0),
        .out_valid (out_valid[1:0]),
        .out_ready (out_ready[1:0]),
        .out_data  (out_data[1:0]),
        .out_side  (b0_side_unused)
    );

    stream_demux_1_2 #(.W(W), .SIDE_W(1)) u_stage_b1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (a_valid_s[1]),
        .in_ready  (b1_ready_s),
        .in_data   (a_data_s[1]),
        .in_route  (a_side_s[1][0]),
        .in_side   (1'b0),
        .out_valid (out_valid[3:2]),
        .out_ready (out_ready[3:2]),
        .out_data  (out_data[3:2]),
        .out_side  (b1_side_unused)
    );

`ifdef STREAM_DEMUX_CNT_EN
    logic [N_OUT-1:0][CNT_W-1:0] cnt_q, cnt_d;

    // Count delivered beats per channel, wrapping naturally.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < N_OUT; i++) begin
            if (out_valid[i] && out_ready[i]) begin
                cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Counter registers; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign beat_cnt = cnt_q;
`endif

endmodule : stream_demux_1_4

// File: tb/tb_stream_demux_1_4.sv
// Directed self-checking bench for stream_demux_1_4 (counter checks when
// STREAM_DEMUX_CNT_EN is defined).
module tb_stream_demux_1_4;

    localparam int W     = 4;
    localparam int CNT_W = 4;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  in_valid;
    logic                  in_ready;
    logic [W-1:0]          in_data;
    logic [1:0]            in_sel;
    logic [3:0]            out_valid;
    logic [3:0]            out_ready;
    logic [3:0][W-1:0]     out_data;
`ifdef STREAM_DEMUX_CNT_EN
    logic [3:0][CNT_W-1:0] beat_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    stream_demux_1_4 #(.W(W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [1:0]   sels [5];
    logic [W-1:0] dats [5];

    initial begin
        sels = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        dats = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 4'h0;
        in_sel    = 2'd0;
        out_ready = 4'hF;
        #12;
        check("reset_out_valid", 64'(out_valid), 64'h0);
        check("reset_out_data", 64'(out_data), 64'h0);
        check("reset_in_ready", 64'(in_ready), 64'h1);
        rst_n = 1'b1;
        step();

        // Single beat to channel 2.
        in_valid = 1'b1; in_data = 4'hA; in_sel = 2'd2;
        #1 check("single_in_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        check("single_mid_valid", 64'(out_valid), 64'h0);
        step();
        check("single_out_valid", 64'(out_valid), 64'h4);
        check("single_out_data", 64'(out_data[2]), 64'hA);
        step();
        check("single_gone", 64'(out_valid), 64'h0);
        check("single_data_hold", 64'(out_data[2]), 64'hA);

        // Back-to-back beats across all channels.
        for (int i = 0; i < 7; i++) begin
            if (i < 5) begin
                in_valid = 1'b1; in_data = dats[i]; in_sel = sels[i];
                #1 check("b2b_in_ready", 64'(in_ready), 64'h1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 5) begin
                check("b2b_valid", 64'(out_valid), 64'(4'b0001 << sels[i-1]));
                check("b2b_data", 64'(out_data[sels[i-1]]), 64'(dats[i-1]));
            end else begin
                check("b2b_idle", 64'(out_valid), 64'h0);
            end
        end

        // Stall channel 0: two beats park, third is refused.
        out_ready = 4'b1110;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h6;
        step();
        in_data = 4'h7;
        #1 check("stall_second_ready", 64'(in_ready), 64'h1);
        step();
        in_data = 4'h8;
        #1 check("stall_full_ready", 64'(in_ready), 64'h0);
        check("stall_head_valid", 64'(out_valid), 64'h1);
        check("stall_head_data", 64'(out_data[0]), 64'h6);
        step(); step();
        check("stall_hold_ready", 64'(in_ready), 64'h0);
        check("stall_hold_data", 64'(out_data[0]), 64'h6);
        out_ready = 4'hF;
        #1 check("drain_ready", 64'(in_ready), 64'h1);
        step();
        in_valid = 1'b0;
        check("drain_b7_valid", 64'(out_valid), 64'h1);
        check("drain_b7_data", 64'(out_data[0]), 64'h7);
        step();
        check("drain_b8_valid", 64'(out_valid), 64'h1);
        check("drain_b8_data", 64'(out_data[0]), 64'h8);
        step();
        check("drain_empty", 64'(out_valid), 64'h0);

        // Channel 0 stalled while channel 3 runs at full rate.
        out_ready = 4'b1110;
        in_valid = 1'b1; in_sel = 2'd0; in_data = 4'h1;
        step();
        in_data = 4'h2;
        step();
        for (int i = 0; i < 5; i++) begin
            if (i < 3) begin
                in_valid = 1'b1; in_sel = 2'd3; in_data = 4'h9 + 4'(i);
                #1 check("ind_in_ready", 64'(in_ready), 64'h1);
            end else begin
                in_valid = 1'b0;
            end
            step();
            if (i >= 1 && i <= 3) begin
                check("ind_valid", 64'(out_valid), 64'h9);
                check("ind_data3", 64'(out_data[3]), 64'(4'h9 + 4'(i - 1)));
            end else begin
                check("ind_valid_ch0", 64'(out_valid), 64'h1);
            end
            check("ind_data0", 64'(out_data[0]), 64'h1);
        end

        // Reset with beats in flight.
        in_valid = 1'b1; in_sel = 2'd2; in_data = 4'hD;
        step();
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check("mid_rst_valid", 64'(out_valid), 64'h0);
        check("mid_rst_data", 64'(out_data), 64'h0);
        check("mid_rst_ready", 64'(in_ready), 64'h1);
        step();
        rst_n = 1'b1;
        out_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            step();
            check("post_rst_idle", 64'(out_valid), 64'h0);
        end

`ifdef STREAM_DEMUX_CNT_EN
        check("cnt_reset", 64'(beat_cnt), 64'h0);
        for (int i = 0; i < 17; i++) begin
            in_valid = 1'b1; in_sel = 2'd1; in_data = 4'(i);
            step();
        end
        in_valid = 1'b0;
        step(); step(); step();
        check("cnt_ch1_wrap", 64'(beat_cnt[1]), 64'h1);
        check("cnt_ch0", 64'(beat_cnt[0]), 64'h0);
        check("cnt_ch2", 64'(beat_cnt[2]), 64'h0);
        check("cnt_ch3", 64'(beat_cnt[3]), 64'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_stream_demux_1_4
